// File: rtl/npc_ras_unit.sv
// npc_ras_unit: fetch PC register, next-PC select and return-address stack.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; wins over stall
//   stall      holds F_PC and suppresses every RAS update for this cycle
//   D_PC       PC of the instruction in D
//   NPCOp      0 PC4, 1 BR, 2 J, 3 JR, 4 RET (5..7 behave as PC4)
//   B_jump     branch-taken flag from the D comparator
//   IMM        instruction[25:0]
//   RA         forwarded rs value (JR target, RET fallback when RAS empty)
//   link       D instruction writes a return address
//   F_PC       current fetch PC (registered)
//   NPC        next PC (combinational)
//   ras_top    top RAS entry, 0 when empty
//   ras_count  number of valid RAS entries
//   ras_ovf    sticky: push while full
//   ras_udf    sticky: RET while empty
module npc_ras_unit #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [WIDTH-1:0]             D_PC,
  input  logic [2:0]                   NPCOp,
  input  logic                         B_jump,
  input  logic [25:0]                  IMM,
  input  logic [WIDTH-1:0]             RA,
  input  logic                         link,
  output logic [WIDTH-1:0]             F_PC,
  output logic [WIDTH-1:0]             NPC,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_udf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_PC4 = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_J   = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;

  logic [WIDTH-1:0] pc_reg;
  logic [PTR_W-1:0] sp_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             udf_reg;
  logic [WIDTH-1:0] stack_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] lnk;
  logic [WIDTH-1:0] top_entry;
  logic             nonempty;
  logic             is_ret;
  logic             push;
  logic             pop;
  logic             update;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] sp_dec;
  logic [PTR_W-1:0] wr_addr;

  assign pc4       = pc_reg + WIDTH'(4);
  assign br_target = D_PC + WIDTH'(4) + {{(WIDTH-18){IMM[15]}}, IMM[15:0], 2'b00};
  assign j_target  = {D_PC[WIDTH-1:28], IMM, 2'b00};
  assign lnk       = D_PC + WIDTH'(8);

  assign nonempty  = (count_reg != '0);
  assign is_ret    = (NPCOp == OP_RET);
  assign push      = link;
  assign pop       = is_ret && nonempty;
  assign update    = !reset && !stall;

  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two,
  // so a push at full lands on the oldest entry.
  assign sp_inc    = sp_reg + PTR_W'(1);
  assign sp_dec    = sp_reg - PTR_W'(1);
  // Push together with pop replaces the current top in place.
  assign wr_addr   = pop ? sp_reg : sp_inc;

  assign top_entry = stack_mem[sp_reg];
  assign ras_top   = nonempty ? top_entry : '0;

  always_comb begin
    NPC = pc4;
    case (NPCOp)
      OP_PC4: NPC = pc4;
      OP_BR:  NPC = B_jump ? br_target : pc4;
      OP_J:   NPC = j_target;
      OP_JR:  NPC = RA;
      OP_RET: NPC = nonempty ? top_entry : RA;
      default: NPC = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      sp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else if (!stall) begin
      pc_reg <= NPC;
      if (push && !pop) begin
        sp_reg <= sp_inc;
        if (count_reg == FULL_COUNT) begin
          ovf_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (pop && !push) begin
        sp_reg    <= sp_dec;
        count_reg <= count_reg - CNT_W'(1);
      end
      if (is_ret && !nonempty) begin
        udf_reg <= 1'b1;
      end
    end
  end

  // Stack contents survive reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (update && push) begin
      stack_mem[wr_addr] <= lnk;
    end
  end

  assign F_PC      = pc_reg;
  assign ras_count = count_reg;
  assign ras_ovf   = ovf_reg;
  assign ras_udf   = udf_reg;

endmodule

// File: tb/tb_npc_ras_unit.sv
module tb_npc_ras_unit;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, stall, B_jump, link;
  logic [31:0] D_PC, RA;
  logic [2:0]  NPCOp;
  logic [25:0] IMM;
  logic [31:0] F_PC, NPC, ras_top;
  logic [3:0]  ras_count;
  logic        ras_ovf, ras_udf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];
  logic        m_ovf, m_udf;

  npc_ras_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .D_PC(D_PC), .NPCOp(NPCOp),
    .B_jump(B_jump), .IMM(IMM), .RA(RA), .link(link), .F_PC(F_PC), .NPC(NPC),
    .ras_top(ras_top), .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    return (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
  endfunction

  function automatic logic [31:0] m_npc();
    logic [31:0] off;
    off = {{14{IMM[15]}}, IMM[15:0], 2'b00};
    case (NPCOp)
      3'd1: return B_jump ? (D_PC + 32'd4 + off) : (m_fpc + 32'd4);
      3'd2: return {D_PC[31:28], IMM, 2'b00};
      3'd3: return RA;
      3'd4: return (m_q.size() > 0) ? m_q[m_q.size()-1] : RA;
      default: return m_fpc + 32'd4;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    logic        was_empty;
    if (reset) begin
      m_fpc = 32'h3000;
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (!stall) begin
      nxt = m_npc();
      was_empty = (m_q.size() == 0);
      if (NPCOp == 3'd4 && was_empty) m_udf = 1'b1;
      if (link && NPCOp == 3'd4 && !was_empty) begin
        m_q[m_q.size()-1] = D_PC + 32'd8;
      end else if (link) begin
        m_q.push_back(D_PC + 32'd8);
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
      end else if (NPCOp == 3'd4 && !was_empty) begin
        void'(m_q.pop_back());
      end
      m_fpc = nxt;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic bj,
                       input logic [31:0] dpc, input logic [25:0] imm,
                       input logic [31:0] ra, input logic lk);
    stall = s; NPCOp = op; B_jump = bj; D_PC = dpc; IMM = imm; RA = ra; link = lk;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (F_PC !== 32'h3000) begin fails++; $display("FAIL reset_fpc got %h want %h", F_PC, 32'h3000); end
    tests++; if (ras_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", ras_count); end
    tests++; if (ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b want 00", ras_ovf, ras_udf); end
    tests++; if (ras_top !== 32'h0) begin fails++; $display("FAIL reset_top got %h want 0", ras_top); end
  endtask

  task automatic test_pc4();
    logic [31:0] exp;
    exp = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
      tick();
      exp = exp + 32'd4;
      tests++; if (F_PC !== exp) begin fails++; $display("FAIL pc4_fpc got %h want %h", F_PC, exp); end
    end
  endtask

  task automatic test_branch_jump();
    drive(1'b0, 3'd1, 1'b1, 32'h3010, 26'h000FFFF, 32'h0, 1'b0);
    tests++; if (NPC !== 32'h3010) begin fails++; $display("FAIL br_taken got %h want %h", NPC, 32'h3010); end
    drive(1'b0, 3'd1, 1'b0, 32'h3010, 26'h000FFFF, 32'h0, 1'b0);
    tests++; if (NPC !== 32'h3010) begin fails++; $display("FAIL br_not_taken got %h want %h", NPC, 32'h3010); end
    tick();
    tests++; if (F_PC !== 32'h3010) begin fails++; $display("FAIL br_fpc got %h want %h", F_PC, 32'h3010); end
    tick();
    tests++; if (F_PC !== 32'h3014) begin fails++; $display("FAIL br_fpc2 got %h want %h", F_PC, 32'h3014); end
    tests++; if (NPC !== 32'h3018) begin fails++; $display("FAIL br_nt_npc got %h want %h", NPC, 32'h3018); end
    drive(1'b0, 3'd2, 1'b0, 32'h3020, 26'h0000C10, 32'h0, 1'b0);
    tests++; if (NPC !== 32'h3040) begin fails++; $display("FAIL j_npc got %h want %h", NPC, 32'h3040); end
    drive(1'b0, 3'd3, 1'b0, 32'h3020, 26'h0000C10, 32'h1234_5678, 1'b0);
    tests++; if (NPC !== 32'h1234_5678) begin fails++; $display("FAIL jr_npc got %h want %h", NPC, 32'h1234_5678); end
    drive(1'b0, 3'd6, 1'b1, 32'h3020, 26'h0000C10, 32'h1234_5678, 1'b1);
    tests++; if (NPC !== 32'h3018) begin fails++; $display("FAIL rsvd_npc got %h want %h", NPC, 32'h3018); end
  endtask

  task automatic test_jal_ret();
    do_reset();
    drive(1'b0, 3'd2, 1'b0, 32'h3000, 26'h0000C00, 32'h0, 1'b1);
    tick();
    tests++; if (ras_top !== 32'h3008 || ras_count !== 4'd1) begin fails++; $display("FAIL jal_push got top %h cnt %0d want 3008 1", ras_top, ras_count); end
    drive(1'b0, 3'd4, 1'b0, 32'h3004, 26'h0, 32'h0000_DEAD, 1'b0);
    tests++; if (NPC !== 32'h3008) begin fails++; $display("FAIL ret_npc got %h want %h", NPC, 32'h3008); end
    tick();
    tests++; if (ras_count !== 4'd0 || F_PC !== 32'h3008) begin fails++; $display("FAIL ret_after got cnt %0d fpc %h want 0 3008", ras_count, F_PC); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 3'd0, 1'b0, 32'h100 * k, 26'h0, 32'h0, 1'b1);
      tick();
    end
    tests++; if (ras_count !== 4'd8 || ras_ovf !== 1'b1 || ras_top !== 32'h908) begin
      fails++; $display("FAIL ovf_state got cnt %0d ovf %b top %h want 8 1 908", ras_count, ras_ovf, ras_top); end
    for (int i = 0; i < 8; i++) begin
      exp = 32'h908 - 32'h100 * i;
      drive(1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0000_BEEF, 1'b0);
      tests++; if (NPC !== exp) begin fails++; $display("FAIL ovf_pop got %h want %h", NPC, exp); end
      tick();
    end
    drive(1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0000_BEEF, 1'b0);
    tests++; if (NPC !== 32'h0000_BEEF) begin fails++; $display("FAIL udf_npc got %h want %h", NPC, 32'h0000_BEEF); end
    tick();
    tests++; if (ras_udf !== 1'b1 || ras_count !== 4'd0) begin fails++; $display("FAIL udf_state got udf %b cnt %0d want 1 0", ras_udf, ras_count); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 1'b0, 32'h5000, 26'h0, 32'h0, 1'b1);
      tick();
      tests++; if (F_PC !== 32'h3000 || ras_count !== 4'd0) begin fails++; $display("FAIL stall_hold got fpc %h cnt %0d want 3000 0", F_PC, ras_count); end
    end
    drive(1'b0, 3'd0, 1'b0, 32'h5000, 26'h0, 32'h0, 1'b1);
    tick();
    tests++; if (F_PC !== 32'h3004 || ras_count !== 4'd1 || ras_top !== 32'h5008) begin
      fails++; $display("FAIL stall_release got fpc %h cnt %0d top %h want 3004 1 5008", F_PC, ras_count, ras_top); end
  endtask

  task automatic test_ret_link_reset();
    do_reset();
    drive(1'b0, 3'd0, 1'b0, 32'h3000, 26'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 3'd4, 1'b0, 32'h4000, 26'h0, 32'h0000_BEEF, 1'b1);
    tests++; if (NPC !== 32'h3008) begin fails++; $display("FAIL retlink_npc got %h want %h", NPC, 32'h3008); end
    tick();
    tests++; if (ras_top !== 32'h4008 || ras_count !== 4'd1) begin fails++; $display("FAIL retlink_top got %h cnt %0d want 4008 1", ras_top, ras_count); end
    // Empty the stack then underflow so that reset has flags to clear.
    drive(1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0000_BEEF, 1'b0);
    tick();
    tick();
    tests++; if (ras_udf !== 1'b1) begin fails++; $display("FAIL pre_reset_udf got %b want 1", ras_udf); end
    reset = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
    tests++; if (F_PC !== 32'h3000 || ras_count !== 4'd0 || ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin
      fails++; $display("FAIL mid_reset got fpc %h cnt %0d ovf %b udf %b want 3000 0 0 0", F_PC, ras_count, ras_ovf, ras_udf); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
            {$urandom} & 32'hFFFF_FFFC, 26'($urandom), $urandom, ($urandom_range(0, 2) == 0));
      exp = m_npc();
      tests++; if (NPC !== exp) begin fails++; $display("FAIL rnd_npc cycle %0d got %h want %h", i, NPC, exp); end
      tick();
      tests++; if (F_PC !== m_fpc || ras_top !== m_top() || ras_count !== 4'(m_q.size()) ||
                   ras_ovf !== m_ovf || ras_udf !== m_udf) begin
        fails++;
        $display("FAIL rnd_state cycle %0d got fpc %h top %h cnt %0d ovf %b udf %b want %h %h %0d %b %b",
                 i, F_PC, ras_top, ras_count, ras_ovf, ras_udf, m_fpc, m_top(), m_q.size(), m_ovf, m_udf);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    m_fpc = 32'h3000; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_pc4();
    test_branch_jump();
    test_jal_ret();
    test_overflow();
    test_stall();
    test_ret_link_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/npc_ras_unit.md
Name: npc_ras_unit

Overview:
- Parametrised next-generation PC unit. Combines the fetch PC register, the next-PC select logic and a return-address stack (RAS) of configurable depth.
- Sits between F and D stages. Targets are computed from D-stage fields; F_PC is held in this block's own register.
- New relative to the current NPC logic:
  - a RET mode that takes its target from the RAS, so `jr $ra` no longer waits on forwarding of $ra;
  - the PC register itself, with stall support;
  - overflow and underflow bookkeeping for the RAS.

Parameters:
- WIDTH, 32, PC/data width; must be ≥ 32.
- RAS_DEPTH, 8, number of RAS entries; must be a power of two, ≥ 2.
- RESET_PC, 32'h0000_3000, F_PC value after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- stall  input  1  1 = hold F_PC; also suppresses all RAS updates this cycle
- D_PC  input  WIDTH  PC of the instruction currently in D
- NPCOp  input  3  0 PC4, 1 BR, 2 J, 3 JR, 4 RET; 5–7 are reserved and treated as PC4
- B_jump  input  1  branch-taken flag from the D comparator
- IMM  input  26  instruction [25:0]
- RA  input  WIDTH  forwarded rs data for JR, and the fallback for RET
- link  input  1  D instruction writes a return address (jal/jalr/bal)
- F_PC  output  WIDTH  current fetch PC (register)
- NPC  output  WIDTH  next PC (combinational)
- ras_top  output  WIDTH  current top entry; 0 when empty
- ras_count  output  $clog2(RAS_DEPTH)+1  number of valid entries
- ras_ovf  output  1  sticky flag: a push occurred while full
- ras_udf  output  1  sticky flag: a RET occurred while empty

Behaviour:
- Reset, synchronous, priority over stall:
  - F_PC = RESET_PC; ras_count = 0; stack pointer = 0; ras_ovf = ras_udf = 0.
  - Stack entries are not cleared.
- Target computation, all arithmetic mod 2^WIDTH:
  - PC4 = F_PC + 4
  - BT = D_PC + 4 + (sign-extended IMM[15:0] << 2)
  - JT = {D_PC[WIDTH-1:28], IMM, 2'b00}
  - LNK = D_PC + 8
- NPC select:
  - PC4 → PC4
  - BR → BT if B_jump, else PC4
  - J → JT
  - JR → RA
  - RET → ras_top if ras_count > 0, else RA
- F_PC update: on each rising edge, if !reset && !stall, F_PC ← NPC. If stall, F_PC holds.
- RAS operations (effective only when !reset && !stall):
  - push = link; pop = (NPCOp == RET) && ras_count > 0.
  - Push only: sp ← sp+1 mod RAS_DEPTH; entry[new sp] ← LNK; count ← min(count+1, RAS_DEPTH).
  - Push at full: overwrites the oldest entry (circular wrap); count stays RAS_DEPTH; ras_ovf ← 1.
  - Pop only: sp ← sp−1 mod RAS_DEPTH; count ← count−1.
  - Push and pop together (e.g. `jalr $ra,$ra` encoded as RET with link): entry[sp] ← LNK in place; sp and count unchanged. NPC still uses the old top, since it is combinational before the edge.
  - RET with count == 0: NPC = RA; stack unchanged; ras_udf ← 1. A push in the same cycle is still performed.
- Timing and flags:
  - ras_top = entry[sp] when count > 0, else 0. Visible one cycle after a push.
  - ras_ovf and ras_udf stay set until reset.
- Latency and stall semantics:
  - NPC is zero-cycle combinational; F_PC has one-cycle latency.
  - Stall repeats the same D instruction, so RAS pushes and pops must not be duplicated; suppressing them under stall guarantees this.
- NPCOp values 5–7 behave exactly as PC4, with no RAS effect and no flag changes.

Test Plan:
- Reset release, NPCOp = PC4, no stall, 3 cycles → F_PC = 0x3000, 0x3004, 0x3008, 0x300C.
- D_PC = 0x3010, BR, IMM[15:0] = 0xFFFF: B_jump=1 → NPC = 0x3010; B_jump=0 with F_PC = 0x3014 → NPC = 0x3018. J with IMM = 0x0000C10, D_PC = 0x3020 → NPC = 0x00003040.
- jal at D_PC = 0x3000 (J, link=1), then RET with RA = 0xDEAD → ras_top = 0x3008 after push, NPC = 0x3008 (not 0xDEAD), ras_count 1 → 0.
- RAS_DEPTH = 8: nine consecutive pushes with D_PC = 0x100·k (k = 1..9) → ras_count = 8, ras_ovf = 1, ras_top = 0x908; eight RETs return 0x908 down to 0x208; a ninth RET → NPC = RA, ras_udf = 1, ras_count = 0.
- Push with stall=1 held 3 cycles, then released → exactly one push (ras_count = 1), F_PC frozen during stall, then advances.
- RET + link in the same cycle with top = 0x3008, D_PC = 0x4000 → NPC = 0x3008; afterwards ras_top = 0x4008, count unchanged. Assert reset mid-sequence → F_PC = 0x3000, count 0, both flags 0 on the next edge.
